product_accumulator: RTL and testbench

- Downstream consumer of the multiplier's valid-only product stream (product + product-valid, no backpressure upstream).
- Sums products over frames of programmable length, with optional early close.
- Completed sums are held in a small output FIFO and presented on a valid/ready interface toward the result sink.
- Upstream cannot be stalled, so overflow of the output FIFO is handled by dropping sums and flagging it, never by stalling.

---
 rtl/product_accumulator_pkg.sv | 19 +
 rtl/product_accumulator_sum_fifo.sv | 52 +++++
 rtl/product_accumulator.sv | 138 +++++++++++++
 tb/tb_product_accumulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types for the product accumulator: FSM state encoding and the
// completed-sum record carried through the output FIFO.
package product_accumulator_pkg;

  localparam int unsigned ACC_DIN_W   = 16;
  localparam int unsigned ACC_GUARD_W = 8;
  localparam int unsigned ACC_SUM_W   = ACC_DIN_W + ACC_GUARD_W;
  localparam int unsigned ACC_MAX_LEN = 255;
  localparam int unsigned ACC_LEN_W   = $clog2(ACC_MAX_LEN + 1);

  typedef enum logic {ACC_IDLE, ACC_ACCUM} acc_state_e;

  typedef struct packed {
    logic [ACC_SUM_W-1:0] sum;
    logic                 ovf;
    logic [ACC_LEN_W-1:0] count;
  } acc_result_t;

endpackage

// File: rtl/product_accumulator_sum_fifo.sv
// Small synchronous FIFO for completed sums; pointers carry one extra bit
// so that full and empty are distinguishable.
module sum_fifo
  import product_accumulator_pkg::*;
#(
  parameter type         T     = acc_result_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_din,
  input  logic i_pop,
  output T     o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  T                 r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A pop frees a slot in the same cycle, so a push into a full FIFO lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_dout = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a valid-only product stream over programmable-length frames and
// queues completed sums; a full queue drops sums instead of stalling.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned DIN_W     = 16,
  parameter int unsigned GUARD_W   = 8,
  parameter int unsigned ACC_W     = DIN_W + GUARD_W,
  parameter int unsigned MAX_LEN   = 255,
  parameter int unsigned LEN_W     = $clog2(MAX_LEN + 1),
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] product_i,
  input  logic             product_valid_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             flush_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sum_ovf_o,
  output logic [LEN_W-1:0] sum_count_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic             drop_o,
  output logic             busy_o
);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [LEN_W-1:0] count;
  } result_t;

  acc_state_e       r_state;
  acc_state_e       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_len_eff;
  logic [ACC_W:0]   w_add;
  logic             w_done;
  logic             r_drop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  result_t          w_push_data;
  result_t          w_head;

  assign w_add     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(product_i);
  assign w_len_eff = (frame_len_i == '0) ? LEN_W'(1) : frame_len_i;

  // Next-state and accumulator datapath; w_done marks a frame completing this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_count_nxt = r_count;
    w_len_nxt   = r_len;
    w_done      = 1'b0;
    case (r_state)
      ACC_IDLE: begin
        if (product_valid_i) begin
          w_acc_nxt   = ACC_W'(product_i);
          w_ovf_nxt   = 1'b0;
          w_count_nxt = LEN_W'(1);
          w_len_nxt   = w_len_eff;
          if (w_len_eff == LEN_W'(1) || flush_i) w_done = 1'b1;
          else                                  w_state_nxt = ACC_ACCUM;
        end
      end
      ACC_ACCUM: begin
        if (product_valid_i) begin
          w_acc_nxt   = w_add[ACC_W-1:0];
          w_ovf_nxt   = r_ovf | w_add[ACC_W];
          w_count_nxt = r_count + LEN_W'(1);
          if (w_count_nxt == r_len || flush_i) begin
            w_done      = 1'b1;
            w_state_nxt = ACC_IDLE;
          end
        end else if (flush_i) begin
          w_done      = 1'b1;
          w_state_nxt = ACC_IDLE;
        end
      end
      default: w_state_nxt = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ACC_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_len   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_count <= w_count_nxt;
      r_len   <= w_len_nxt;
      r_drop  <= r_drop | w_drop;
    end
  end

  assign w_push_data = '{sum: w_acc_nxt, ovf: w_ovf_nxt, count: w_count_nxt};

  // When full the FIFO is non-empty, so only a same-cycle pop saves the sum.
  assign w_drop = w_done && w_full && !sum_ready_i;

  sum_fifo #(
    .T     (result_t),
    .DEPTH (OUT_DEPTH)
  ) u_sum_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_done),
    .i_din   (w_push_data),
    .i_pop   (sum_ready_i),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign sum_o       = w_head.sum;
  assign sum_ovf_o   = w_head.ovf;
  assign sum_count_o = w_head.count;
  assign sum_valid_o = !w_empty;
  assign drop_o      = r_drop;
  assign busy_o      = (r_state == ACC_ACCUM);

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: table of per-cycle stimulus
// feeding a scoreboard, plus hand-written overflow, drop and reset sequences.
module tb_product_accumulator;

  typedef struct {
    logic        v;
    logic [15:0] p;
    logic [7:0]  len;
    logic        fl;
    logic        rdy;
    logic        push;
    logic [23:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    logic [23:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] product_i;
  logic        product_valid_i;
  logic [7:0]  frame_len_i;
  logic        flush_i;
  logic        sum_ready_i;

  logic [23:0] sum_o;
  logic        sum_ovf_o;
  logic [7:0]  sum_count_o;
  logic        sum_valid_o;
  logic        drop_o;
  logic        busy_o;

  logic [15:0] g_sum_o;
  logic        g_sum_ovf_o;
  logic [7:0]  g_sum_count_o;
  logic        g_sum_valid_o;
  logic        g_drop_o;
  logic        g_busy_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic pend_lat = 1'b0;
  vec_t tbl[19];

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk             (clk),
    .rst             (rst),
    .product_i       (product_i),
    .product_valid_i (product_valid_i),
    .frame_len_i     (frame_len_i),
    .flush_i         (flush_i),
    .sum_o           (sum_o),
    .sum_ovf_o       (sum_ovf_o),
    .sum_count_o     (sum_count_o),
    .sum_valid_o     (sum_valid_o),
    .sum_ready_i     (sum_ready_i),
    .drop_o          (drop_o),
    .busy_o          (busy_o)
  );

  // Zero-guard build so that a two-product frame can carry out of the sum.
  product_accumulator #(.GUARD_W(0)) u_dut_g0 (
    .clk             (clk),
    .rst             (rst),
    .product_i       (product_i),
    .product_valid_i (product_valid_i),
    .frame_len_i     (frame_len_i),
    .flush_i         (flush_i),
    .sum_o           (g_sum_o),
    .sum_ovf_o       (g_sum_ovf_o),
    .sum_count_o     (g_sum_count_o),
    .sum_valid_o     (g_sum_valid_o),
    .sum_ready_i     (sum_ready_i),
    .drop_o          (g_drop_o),
    .busy_o          (g_busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] p, input logic [7:0] len,
                              input logic fl, input logic rdy, input logic push,
                              input logic [23:0] sum, input logic ovf, input logic [7:0] cnt);
    vec_t r;
    r.v = v; r.p = p; r.len = len; r.fl = fl; r.rdy = rdy;
    r.push = push; r.sum = sum; r.ovf = ovf; r.cnt = cnt;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the clock edge; an expected sum is
  // queued here and must be valid right after the edge that captures it.
  task automatic apply(input vec_t r);
    exp_t e;
    @(posedge clk);
    #1;
    if (pend_lat) check("latency_valid", 32'(sum_valid_o), 32'd1);
    product_valid_i = r.v;
    product_i       = r.p;
    frame_len_i     = r.len;
    flush_i         = r.fl;
    sum_ready_i     = r.rdy;
    pend_lat        = r.push;
    if (r.push) begin
      e.sum = r.sum; e.ovf = r.ovf; e.cnt = r.cnt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) apply(mk(1'b0, 16'd0, 8'd0, 1'b0, rdy, 1'b0, 24'd0, 1'b0, 8'd0));
  endtask

  // Scoreboard: every accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && sum_valid_o && sum_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum: got sum 0x%0h count %0d, none required", sum_o, sum_count_o);
      end else begin
        e = sb.pop_front();
        check("sum", 32'(sum_o), 32'(e.sum));
        check("sum_ovf", 32'(sum_ovf_o), 32'(e.ovf));
        check("sum_count", 32'(sum_count_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; product_i = '0; product_valid_i = 1'b0;
    frame_len_i = '0; flush_i = 1'b0; sum_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(sum_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_drop", 32'(drop_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_count", 32'(sum_count_o), 32'd0);
    check("rst_ovf", 32'(sum_ovf_o), 32'd0);
    rst = 1'b1;

    // v, p, len, flush, ready, push, sum, ovf, count
    tbl[0]  = mk(1, 16'd3,   8'd4, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[1]  = mk(1, 16'd5,   8'd4, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[2]  = mk(1, 16'd7,   8'd4, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[3]  = mk(1, 16'd9,   8'd4, 0, 1, 1, 24'd24,  0, 8'd4);
    tbl[4]  = mk(1, 16'd1,   8'd3, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[5]  = mk(1, 16'd2,   8'd3, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[6]  = mk(1, 16'd3,   8'd3, 0, 1, 1, 24'd6,   0, 8'd3);
    tbl[7]  = mk(1, 16'd10,  8'd3, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[8]  = mk(1, 16'd20,  8'd3, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[9]  = mk(1, 16'd30,  8'd3, 0, 1, 1, 24'd60,  0, 8'd3);
    tbl[10] = mk(1, 16'd100, 8'd8, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[11] = mk(1, 16'd200, 8'd8, 1, 1, 1, 24'd300, 0, 8'd2);
    tbl[12] = mk(0, 16'd0,   8'd8, 1, 1, 0, 24'd0,   0, 8'd0);
    tbl[13] = mk(0, 16'd0,   8'd8, 1, 1, 0, 24'd0,   0, 8'd0);
    tbl[14] = mk(1, 16'd42,  8'd0, 0, 1, 1, 24'd42,  0, 8'd1);
    tbl[15] = mk(0, 16'd0,   8'd0, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[16] = mk(1, 16'd5,   8'd8, 0, 1, 0, 24'd0,   0, 8'd0);
    tbl[17] = mk(0, 16'd0,   8'd8, 1, 1, 1, 24'd5,   0, 8'd1);
    tbl[18] = mk(0, 16'd0,   8'd0, 0, 1, 0, 24'd0,   0, 8'd0);
    for (int i = 0; i < 19; i++) apply(tbl[i]);
    idle(3, 1'b1);
    check("table_drained", 32'(sb.size()), 32'd0);
    check("table_idle_valid", 32'(sum_valid_o), 32'd0);
    check("table_idle_busy", 32'(busy_o), 32'd0);

    // Push into a full FIFO accepted because the head pops in the same cycle.
    apply(mk(1, 16'd11, 8'd1, 0, 0, 1, 24'd11, 0, 8'd1));
    apply(mk(1, 16'd12, 8'd1, 0, 0, 1, 24'd12, 0, 8'd1));
    apply(mk(1, 16'd13, 8'd1, 0, 1, 1, 24'd13, 0, 8'd1));
    idle(4, 1'b1);
    check("full_pop_push_drop", 32'(drop_o), 32'd0);
    check("full_pop_push_drained", 32'(sb.size()), 32'd0);

    // Carry out of the sum on the zero-guard build.
    apply(mk(1, 16'hFFFF, 8'd2, 0, 1, 0, 24'd0, 0, 8'd0));
    apply(mk(1, 16'hFFFF, 8'd2, 0, 1, 1, 24'h01FFFE, 0, 8'd2));
    idle(1, 1'b1);
    check("g0_valid", 32'(g_sum_valid_o), 32'd1);
    check("g0_sum", 32'(g_sum_o), 32'h0000FFFE);
    check("g0_ovf", 32'(g_sum_ovf_o), 32'd1);
    check("g0_count", 32'(g_sum_count_o), 32'd2);
    check("g0_busy", 32'(g_busy_o), 32'd0);
    check("g0_drop", 32'(g_drop_o), 32'd0);
    idle(2, 1'b1);

    // Third single-product frame hits a full FIFO with no pop and is dropped.
    apply(mk(1, 16'd21, 8'd1, 0, 0, 1, 24'd21, 0, 8'd1));
    apply(mk(1, 16'd22, 8'd1, 0, 0, 1, 24'd22, 0, 8'd1));
    apply(mk(1, 16'd23, 8'd1, 0, 0, 0, 24'd0,  0, 8'd0));
    idle(1, 1'b0);
    check("drop_set", 32'(drop_o), 32'd1);
    check("drop_head_sum", 32'(sum_o), 32'd21);
    idle(1, 1'b0);
    check("drop_head_stable", 32'(sum_o), 32'd21);
    check("drop_head_count", 32'(sum_count_o), 32'd1);
    idle(4, 1'b1);
    check("drop_drained", 32'(sb.size()), 32'd0);
    check("drop_after_valid", 32'(sum_valid_o), 32'd0);
    check("drop_sticky", 32'(drop_o), 32'd1);

    // Reset mid-frame with one sum queued discards both.
    apply(mk(1, 16'd7, 8'd1, 0, 0, 0, 24'd0, 0, 8'd0));
    apply(mk(1, 16'd1, 8'd4, 0, 0, 0, 24'd0, 0, 8'd0));
    apply(mk(1, 16'd2, 8'd4, 0, 0, 0, 24'd0, 0, 8'd0));
    idle(1, 1'b0);
    check("pre_rst_valid", 32'(sum_valid_o), 32'd1);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("mid_rst_valid", 32'(sum_valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_drop", 32'(drop_o), 32'd0);
    check("mid_rst_sum", 32'(sum_o), 32'd0);
    apply(mk(1, 16'd5, 8'd2, 0, 1, 0, 24'd0,  0, 8'd0));
    apply(mk(1, 16'd6, 8'd2, 0, 1, 1, 24'd11, 0, 8'd2));
    idle(3, 1'b1);
    check("final_drained", 32'(sb.size()), 32'd0);
    check("final_valid", 32'(sum_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
